fetch_unit: RTL and testbench

//   Instruction-fetch stage of the multi-cycle CPU; sits directly upstream of the instruction memory.

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM, holds IR for decode.
// Latency: IRValid rises MEM_LAT+1 cycles after entering ADDR (min 3 cycles per instruction).
// Backpressure: IR/IRValid held in WAIT until IRAck; no new fetch is issued meanwhile.
// Optional feature: define FETCH_ALIGN_CHK_EN to trap misaligned PCs like out-of-range ones.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256,
  parameter int          MEM_LAT   = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] IAddr,
  output logic        RW,
  input  logic [31:0] IDataOut,
  output logic [31:0] IR,
  output logic        IRValid,
  input  logic        IRAck,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchImm,
  input  logic [25:0] JumpAddr,
  output logic [31:0] CurPC,
  output logic [31:0] PC4,
  output logic        FetchErr,
  output logic        Halted
);

  // Highest byte address at which a full word can still be fetched.
  localparam logic [31:0] LAST_PC  = 32'(MEM_BYTES - 4);
  localparam logic [2:0]  LAT_LAST = 3'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LATCH = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic [31:0] r_cur_pc;
  logic        r_fetch_err;
  logic        r_halted;
  logic [2:0]  r_lat_cnt;

  logic        w_bad_pc;
  logic        w_rw;
  logic        w_ack;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_cur_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_cur_pc4    = r_cur_pc + 32'd4;
  assign w_br_target  = w_pc_plus4 + (BranchImm << 2);
  assign w_jmp_target = {w_cur_pc4[31:28], JumpAddr, 2'b00};
  // Only a live instruction can be acknowledged; stray acks elsewhere are ignored.
  assign w_ack        = (r_state == S_WAIT) && r_ir_valid && IRAck;

  // A PC that cannot be fetched sends the FSM to HALT without touching memory.
`ifdef FETCH_ALIGN_CHK_EN
  assign w_bad_pc = (r_pc > LAST_PC) || (r_pc[1:0] != 2'b00);
`else
  assign w_bad_pc = (r_pc > LAST_PC);
`endif

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and the memory read strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_rw        = 1'b0;
    case (r_state)
      S_IDLE:  w_state_nxt = S_ADDR;
      S_ADDR: begin
        if (w_bad_pc) begin
          w_state_nxt = S_HALT;
        end else begin
          w_rw = 1'b1;
          if (r_lat_cnt == LAT_LAST) w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_ack) w_state_nxt = (PCSrc == 2'b11) ? S_HALT : S_ADDR;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PC, IR and status registers; everything clears immediately on Reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc        <= RESET_PC;
      r_ir        <= 32'h0;
      r_ir_valid  <= 1'b0;
      r_cur_pc    <= 32'h0;
      r_fetch_err <= 1'b0;
      r_halted    <= 1'b0;
      r_lat_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_bad_pc) begin
            r_fetch_err <= 1'b1;
            r_lat_cnt   <= 3'd0;
          end else if (r_lat_cnt == LAT_LAST) begin
            r_lat_cnt <= 3'd0;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_LATCH: begin
          r_ir       <= IDataOut;
          r_cur_pc   <= r_pc;
          r_ir_valid <= 1'b1;
        end
        S_WAIT: begin
          if (w_ack) begin
            r_ir_valid <= 1'b0;
            case (PCSrc)
              2'b00:   r_pc <= w_pc_plus4;
              2'b01:   r_pc <= w_br_target;
              2'b10:   r_pc <= w_jmp_target;
              default: r_halted <= 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign IAddr    = r_pc;
  assign RW       = w_rw;
  assign IR       = r_ir;
  assign IRValid  = r_ir_valid;
  assign CurPC    = r_cur_pc;
  assign PC4      = w_cur_pc4;
  assign FetchErr = r_fetch_err;
  assign Halted   = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance with MEM_LAT=1 for the main flow,
// a second with MEM_LAT=3 for latency and mid-fetch reset behaviour.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:63];

  // Main instance signals (MEM_LAT=1).
  logic        Reset;
  logic [31:0] IAddr, IDataOut, IR, CurPC, PC4, BranchImm;
  logic        RW, IRValid, IRAck, FetchErr, Halted;
  logic [1:0]  PCSrc;
  logic [25:0] JumpAddr;

  // Second instance signals (MEM_LAT=3).
  logic        Reset3;
  logic [31:0] IAddr3, IDataOut3, IR3, CurPC3, PC43;
  logic        RW3, IRValid3, FetchErr3, Halted3;

  fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(256), .MEM_LAT(1)) u_dut (
    .CLK(CLK), .Reset(Reset), .IAddr(IAddr), .RW(RW), .IDataOut(IDataOut),
    .IR(IR), .IRValid(IRValid), .IRAck(IRAck), .PCSrc(PCSrc),
    .BranchImm(BranchImm), .JumpAddr(JumpAddr), .CurPC(CurPC), .PC4(PC4),
    .FetchErr(FetchErr), .Halted(Halted)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(256), .MEM_LAT(3)) u_dut3 (
    .CLK(CLK), .Reset(Reset3), .IAddr(IAddr3), .RW(RW3), .IDataOut(IDataOut3),
    .IR(IR3), .IRValid(IRValid3), .IRAck(1'b1), .PCSrc(2'b00),
    .BranchImm(32'h0), .JumpAddr(26'h0), .CurPC(CurPC3), .PC4(PC43),
    .FetchErr(FetchErr3), .Halted(Halted3)
  );

  // ROM model: word read registered while RW is high, held otherwise.
  always @(posedge CLK) if (RW)  IDataOut  <= rom[IAddr[7:2]];
  always @(posedge CLK) if (RW3) IDataOut3 <= rom[IAddr3[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits for IRValid on the main instance; returns cycles taken (limit+1 on timeout).
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (IRValid !== 1'b1 && n <= 20) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {31'b0, IRValid}, 32'h1);
  endtask

  task automatic wait_valid3(input string tag, output int n);
    n = 0;
    while (IRValid3 !== 1'b1 && n <= 30) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {31'b0, IRValid3}, 32'h1);
  endtask

  // One accepted acknowledge of the main instance with the given next-PC select.
  task automatic ack(input logic [1:0] src, input logic [31:0] imm, input logic [25:0] ja);
    PCSrc = src; BranchImm = imm; JumpAddr = ja; IRAck = 1'b1;
    tick();
    IRAck = 1'b0; PCSrc = 2'b00; BranchImm = 32'h0; JumpAddr = 26'h0;
  endtask

  initial begin
    int n;
    logic saw;
    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0]  = 32'h2001_0005;
    rom[1]  = 32'h2002_0007;
    rom[2]  = 32'h2003_0009;
    rom[16] = 32'h0800_1234;
    rom[63] = 32'hDEAD_BEEF;

    Reset = 1'b1; Reset3 = 1'b1;
    IRAck = 1'b0; PCSrc = 2'b00; BranchImm = 32'h0; JumpAddr = 26'h0;
    #1;
    chk("rst_ir", IR, 32'h0);
    chk("rst_irvalid", {31'b0, IRValid}, 32'h0);
    chk("rst_rw", {31'b0, RW}, 32'h0);
    chk("rst_fetcherr", {31'b0, FetchErr}, 32'h0);
    chk("rst_halted", {31'b0, Halted}, 32'h0);
    chk("rst_iaddr", IAddr, 32'h0);
    tick(); tick();

    // Sequential fetch with IRAck held high.
    IRAck = 1'b1;
    Reset = 1'b0;
    tick();
    chk("addr_rw", {31'b0, RW}, 32'h1);
    chk("addr_iaddr", IAddr, 32'h0);
    wait_valid("fetch0", n);
    chk("fetch0_latency", 32'(n), 32'd2);
    chk("fetch0_ir", IR, 32'h2001_0005);
    chk("fetch0_curpc", CurPC, 32'h0);
    chk("fetch0_pc4", PC4, 32'h4);
    tick();
    chk("ack_drops_valid", {31'b0, IRValid}, 32'h0);
    wait_valid("fetch1", n);
    IRAck = 1'b0;
    chk("fetch1_ir", IR, 32'h2002_0007);
    chk("fetch1_curpc", CurPC, 32'h4);

    // Stall in WAIT: nothing moves while IRAck is low.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_ir", IR, 32'h2002_0007);
      chk("stall_curpc", CurPC, 32'h4);
      chk("stall_valid", {31'b0, IRValid}, 32'h1);
      chk("stall_rw", {31'b0, RW}, 32'h0);
      chk("stall_iaddr", IAddr, 32'h4);
    end

    // Sequential to PC=8, then branch back by -2 words: 8+4-8 = 4.
    ack(2'b00, 32'h0, 26'h0);
    wait_valid("fetch8", n);
    chk("fetch8_curpc", CurPC, 32'h8);
    chk("fetch8_ir", IR, 32'h2003_0009);
    ack(2'b01, 32'hFFFF_FFFE, 26'h0);
    wait_valid("branch", n);
    chk("branch_curpc", CurPC, 32'h4);
    chk("branch_ir", IR, 32'h2002_0007);

    // Jump to word index 0x10 -> byte address 0x40.
    ack(2'b10, 32'h0, 26'h10);
    wait_valid("jump", n);
    chk("jump_curpc", CurPC, 32'h40);
    chk("jump_pc4", PC4, 32'h44);
    chk("jump_ir", IR, 32'h0800_1234);

    // Halt on PCSrc=11: PC unchanged, no further reads.
    ack(2'b11, 32'h0, 26'h0);
    chk("halt_halted", {31'b0, Halted}, 32'h1);
    chk("halt_valid", {31'b0, IRValid}, 32'h0);
    saw = 1'b0;
    IRAck = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (RW) saw = 1'b1;
    end
    IRAck = 1'b0;
    chk("halt_rw_quiet", {31'b0, saw}, 32'h0);
    chk("halt_iaddr", IAddr, 32'h40);

    // Reset out of HALT, fetch resumes from RESET_PC.
    Reset = 1'b1;
    #1;
    chk("rst2_halted", {31'b0, Halted}, 32'h0);
    chk("rst2_ir", IR, 32'h0);
    chk("rst2_iaddr", IAddr, 32'h0);
    tick();
    Reset = 1'b0;
    wait_valid("resume", n);
    chk("resume_curpc", CurPC, 32'h0);
    chk("resume_ir", IR, 32'h2001_0005);

    // Last in-range word at MEM_BYTES-4 = 0xFC.
    ack(2'b10, 32'h0, 26'h3F);
    wait_valid("lastword", n);
    chk("lastword_curpc", CurPC, 32'hFC);
    chk("lastword_ir", IR, 32'hDEAD_BEEF);
    chk("lastword_err", {31'b0, FetchErr}, 32'h0);

    // Jump to 0x100: out of range, no read, FetchErr, not Halted.
    ack(2'b10, 32'h0, 26'h40);
    chk("oor_rw", {31'b0, RW}, 32'h0);
    chk("oor_iaddr", IAddr, 32'h100);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (RW || IRValid) saw = 1'b1;
    end
    chk("oor_quiet", {31'b0, saw}, 32'h0);
    chk("oor_fetcherr", {31'b0, FetchErr}, 32'h1);
    chk("oor_halted", {31'b0, Halted}, 32'h0);

    // MEM_LAT=3 instance: latency, then reset while in ADDR.
    Reset3 = 1'b0;
    tick();
    chk("l3_addr_rw", {31'b0, RW3}, 32'h1);
    wait_valid3("l3_fetch0", n);
    chk("l3_latency", 32'(n), 32'd4);
    chk("l3_ir", IR3, 32'h2001_0005);
    tick();
    chk("l3_addr4_rw", {31'b0, RW3}, 32'h1);
    chk("l3_addr4_iaddr", IAddr3, 32'h4);
    tick();
    Reset3 = 1'b1;
    #1;
    chk("l3_rst_ir", IR3, 32'h0);
    chk("l3_rst_rw", {31'b0, RW3}, 32'h0);
    chk("l3_rst_iaddr", IAddr3, 32'h0);
    chk("l3_rst_valid", {31'b0, IRValid3}, 32'h0);
    tick();
    Reset3 = 1'b0;
    tick();
    chk("l3_refetch_iaddr", IAddr3, 32'h0);
    wait_valid3("l3_refetch", n);
    chk("l3_refetch_latency", 32'(n), 32'd4);
    chk("l3_refetch_ir", IR3, 32'h2001_0005);
    chk("l3_refetch_curpc", CurPC3, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
